// File: rtl/math_pkg.sv
// Shared encodings for the byte-serial math unit and its host-side driver.
// Holds unit opcodes, host command codes and driver state encoding.
package math_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_CLR = 8'h01;
  localparam logic [7:0] OP_LDB = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SHL = 8'h04;
  localparam logic [7:0] OP_SHR = 8'h05;

  localparam logic [7:0] SHIFT_BYTE = 8'h08;

  typedef enum logic [2:0] {
    CMD_LOAD  = 3'd0,
    CMD_READ  = 3'd1,
    CMD_PEEK  = 3'd2,
    CMD_ADD   = 3'd3,
    CMD_SHL   = 3'd4,
    CMD_SHR   = 3'd5,
    CMD_CLEAR = 3'd6,
    CMD_NOP   = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOADSEQ = 3'd1,
    S_READSEQ = 3'd2,
    S_SINGLE  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Unit opcode for the commands that map onto exactly one unit op.
  function automatic logic [7:0] single_op(cmd_e c);
    logic [7:0] op;
    case (c)
      CMD_ADD:   op = OP_ADD;
      CMD_SHL:   op = OP_SHL;
      CMD_SHR:   op = OP_SHR;
      CMD_CLEAR: op = OP_CLR;
      default:   op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/math_driver_if.sv
// Host command/response handshake of the math driver.
// master = host side, slave = driver side.
interface math_driver_if
  import math_pkg::*;
#(
  parameter int BITS = 64
);
  logic            cmd_valid;
  logic            cmd_ready;
  cmd_e            cmd_op;
  logic [BITS-1:0] cmd_data;
  logic            rsp_valid;
  logic [BITS-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/math_driver.sv
// Host-side initiator for the byte-serial math accumulator unit: expands wide
// commands into 8-bit op/data streams and reassembles wide results.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | cmd_ready high, unit idle
// LOADSEQ | LDB / SHL-8 pairs, top byte first (LOAD, second half of PEEK)
// READSEQ | SHR-8 per byte, capturing the pre-shift low byte
// SINGLE  | one ADD/SHL/SHR/CLR op
// DONE    | one-cycle response
module math_driver
  import math_pkg::*;
#(
  parameter int BITS = 64
) (
  input  logic         clk,
  input  logic         rst,
  math_driver_if.slave host,
  output logic [7:0]   unit_op_o,
  output logic [7:0]   unit_wdata_o,
  input  logic [7:0]   unit_rdata_i
);

  localparam int NBYTES = BITS / 8;
  localparam int CW     = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

  state_e          state_q, state_d;
  cmd_e            cmd_q, cmd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            shl_q, shl_d;
  logic [BITS-1:0] buf_q, buf_d;
  logic [7:0]      op_q, op_d;
  logic [7:0]      wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_NOP;
      cnt_q   <= '0;
      shl_q   <= 1'b0;
      buf_q   <= '0;
      op_q    <= OP_NOP;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      shl_q   <= shl_d;
      buf_q   <= buf_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
    end
  end

  // The buffer rotates left one byte per LDB, so the next byte to load is
  // always on top and a full LOAD leaves the buffer as it started (PEEK).
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    shl_d   = shl_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (host.cmd_valid) begin
          cmd_d = host.cmd_op;
          buf_d = host.cmd_data;
          cnt_d = CNT_LAST;
          shl_d = 1'b0;
          case (host.cmd_op)
            CMD_LOAD:           state_d = S_LOADSEQ;
            CMD_READ, CMD_PEEK: state_d = S_READSEQ;
            CMD_NOP:            state_d = S_DONE;
            default:            state_d = S_SINGLE;
          endcase
        end
      end
      S_LOADSEQ: begin
        if (shl_q) begin
          shl_d = 1'b0;
          cnt_d = cnt_q - 1'b1;
        end else begin
          buf_d = {buf_q[BITS-9:0], buf_q[BITS-1 -: 8]};
          if (cnt_q == '0) state_d = S_DONE;
          else             shl_d   = 1'b1;
        end
      end
      S_READSEQ: begin
        buf_d = {unit_rdata_i, buf_q[BITS-1:8]};
        if (cnt_q == '0) begin
          if (cmd_q == CMD_PEEK) begin
            state_d = S_LOADSEQ;
            cnt_d   = CNT_LAST;
            shl_d   = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SINGLE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Registered unit outputs are derived from the state being entered.
    op_d    = OP_NOP;
    wdata_d = '0;
    case (state_d)
      S_LOADSEQ: begin
        if (shl_d) begin
          op_d    = OP_SHL;
          wdata_d = SHIFT_BYTE;
        end else begin
          op_d    = OP_LDB;
          wdata_d = buf_d[BITS-1 -: 8];
        end
      end
      S_READSEQ: begin
        op_d    = OP_SHR;
        wdata_d = SHIFT_BYTE;
      end
      S_SINGLE: begin
        op_d    = single_op(cmd_d);
        wdata_d = (cmd_d == CMD_CLEAR) ? 8'h00 : buf_d[7:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    host.rsp_data = '0;
    if (state_q == S_DONE) begin
      if (cmd_q == CMD_READ || cmd_q == CMD_PEEK) host.rsp_data = buf_q;
      else host.rsp_data = {{(BITS-8){1'b0}}, unit_rdata_i};
    end
  end

  assign host.cmd_ready = (state_q == S_IDLE);
  assign host.rsp_valid = (state_q == S_DONE);
  assign unit_op_o      = op_q;
  assign unit_wdata_o   = wdata_q;

endmodule

// File: tb/tb_math_driver.sv
// Bench for math_driver wired to a behavioural model of the math unit;
// expected op streams and responses are queued at issue and checked by a monitor.
module tb_math_driver;
  import math_pkg::*;

  localparam int BITS = 64;
  localparam int NB   = BITS / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_n;
  always #5 clk = ~clk;
  assign rst_n = ~rst;

  logic [7:0]      unit_op, unit_wdata, unit_rdata;
  logic [BITS-1:0] acc;

  math_driver_if #(.BITS(BITS)) host ();

  math_driver #(.BITS(BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (host),
    .unit_op_o    (unit_op),
    .unit_wdata_o (unit_wdata),
    .unit_rdata_i (unit_rdata)
  );

  // Math unit model: ops take effect at the clock edge ending their cycle.
  always @(posedge clk) begin
    if (!rst_n) acc <= '0;
    else begin
      case (unit_op)
        OP_CLR: acc <= '0;
        OP_LDB: acc <= {acc[BITS-1:8], unit_wdata};
        OP_ADD: acc <= acc + {{(BITS-8){1'b0}}, unit_wdata};
        OP_SHL: acc <= (unit_wdata >= 8'd64) ? '0 : acc << unit_wdata;
        OP_SHR: acc <= (unit_wdata >= 8'd64) ? '0 : acc >> unit_wdata;
        default: ;
      endcase
    end
  end
  assign unit_rdata = acc[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] op; logic [7:0] wd; } op_t;
  typedef struct { int cyc; logic [BITS-1:0] d; } rsp_t;

  op_t  opq[$];
  rsp_t rspq[$];
  op_t  mon_op;
  rsp_t mon_rsp;

  int n_vec = 0, n_bad = 0, n_issued = 0, n_acc = 0, n_rsp = 0, n_abort = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (host.cmd_valid && host.cmd_ready) n_acc++;
      if (unit_op != OP_NOP) begin
        check("ready_low_during_op", 64'(host.cmd_ready), 64'd0);
        if (opq.size() == 0) check("spurious_op", 64'(unit_op), 64'(OP_NOP));
        else begin
          mon_op = opq.pop_front();
          check("op_cycle", 64'(cyc), 64'(mon_op.cyc));
          check("op_code", 64'(unit_op), 64'(mon_op.op));
          check("op_data", 64'(unit_wdata), 64'(mon_op.wd));
        end
      end
      if (host.rsp_valid) begin
        n_rsp++;
        if (rspq.size() == 0) check("spurious_rsp", 64'(host.rsp_valid), 64'd0);
        else begin
          mon_rsp = rspq.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(mon_rsp.cyc));
          check("rsp_data", host.rsp_data, mon_rsp.d);
        end
      end
    end
  end

  task automatic push_op(inout int c, input logic [7:0] op, input logic [7:0] wd);
    opq.push_back(op_t'{cyc: c, op: op, wd: wd});
    c++;
  endtask

  task automatic push_load(input logic [BITS-1:0] v, inout int c);
    for (int i = NB - 1; i >= 0; i--) begin
      push_op(c, OP_LDB, v[8*i +: 8]);
      if (i > 0) push_op(c, OP_SHL, 8'h08);
    end
  endtask

  task automatic push_read(inout int c);
    for (int i = 0; i < NB; i++) push_op(c, OP_SHR, 8'h08);
  endtask

  task automatic issue(cmd_e op, logic [BITS-1:0] data, logic [BITS-1:0] exp, bit hold);
    int c;
    int waited;
    host.cmd_valid = 1'b1;
    host.cmd_op    = op;
    host.cmd_data  = data;
    waited = 0;
    while (!host.cmd_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!host.cmd_ready) begin
      check("ready_timeout", 64'(host.cmd_ready), 64'd1);
      host.cmd_valid = 1'b0;
      return;
    end
    c = cyc + 1;
    case (op)
      CMD_LOAD:  push_load(data, c);
      CMD_READ:  push_read(c);
      CMD_PEEK:  begin push_read(c); push_load(exp, c); end
      CMD_ADD:   push_op(c, OP_ADD, data[7:0]);
      CMD_SHL:   push_op(c, OP_SHL, data[7:0]);
      CMD_SHR:   push_op(c, OP_SHR, data[7:0]);
      CMD_CLEAR: push_op(c, OP_CLR, 8'h00);
      default: ;
    endcase
    rspq.push_back(rsp_t'{cyc: c, d: exp});
    n_issued++;
    @(posedge clk); #1;
    if (!hold) begin
      host.cmd_valid = 1'b0;
      host.cmd_data  = '1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((opq.size() != 0 || rspq.size() != 0 || !host.cmd_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_rsp_queue", 64'(rspq.size()), 64'd0);
    check("drain_op_queue", 64'(opq.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    host.cmd_valid = 1'b0;
    host.cmd_op    = CMD_NOP;
    host.cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_unit_op", 64'(unit_op), 64'h00);
    check("reset_unit_wdata", 64'(unit_wdata), 64'h00);
    check("reset_rsp_valid", 64'(host.rsp_valid), 64'd0);
    check("reset_rsp_data", host.rsp_data, 64'd0);
    check("reset_cmd_ready", 64'(host.cmd_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(CMD_LOAD, 64'h0123_4567_89AB_CDEF, 64'hEF, 1'b0);
    issue(CMD_READ, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0);
    issue(CMD_READ, 64'h0, 64'h0, 1'b0);

    issue(CMD_LOAD, 64'hFEDC_BA98_7654_3210, 64'h10, 1'b0);
    issue(CMD_PEEK, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b0);
    issue(CMD_READ, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b0);

    issue(CMD_LOAD, 64'hFF, 64'hFF, 1'b0);
    issue(CMD_ADD, 64'hFF, 64'hFE, 1'b0);
    issue(CMD_READ, 64'h0, 64'h1FE, 1'b0);

    issue(CMD_LOAD, 64'h0F, 64'h0F, 1'b0);
    issue(CMD_SHL, 64'h04, 64'hF0, 1'b0);
    issue(CMD_SHR, 64'h40, 64'h00, 1'b0);
    issue(CMD_READ, 64'h0, 64'h0, 1'b0);
    drain();

    // cmd_valid held high across back-to-back commands
    issue(CMD_LOAD, 64'h1122, 64'h22, 1'b1);
    issue(CMD_ADD, 64'hFFFF_FFFF_FFFF_FF10, 64'h32, 1'b1);
    issue(CMD_READ, 64'h0, 64'h1132, 1'b1);
    issue(CMD_CLEAR, 64'hAB, 64'h00, 1'b1);
    issue(CMD_NOP, 64'h0, 64'h00, 1'b0);
    drain();

    // Reset during a LOAD aborts it without a response
    issue(CMD_LOAD, 64'hAAAA_5555_AAAA_5555, 64'h55, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    n_abort++;
    opq.delete();
    rspq.delete();
    @(posedge clk); #1;
    check("abort_unit_op", 64'(unit_op), 64'h00);
    check("abort_cmd_ready", 64'(host.cmd_ready), 64'd1);
    check("abort_rsp_valid", 64'(host.rsp_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    issue(CMD_LOAD, 64'h5A5A_1234_0000_FFFF, 64'hFF, 1'b0);
    issue(CMD_READ, 64'h0, 64'h5A5A_1234_0000_FFFF, 1'b0);
    drain();

    check("accept_count", 64'(n_acc), 64'(n_issued));
    check("rsp_count", 64'(n_rsp), 64'(n_issued - n_abort));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/math_driver.md
Name: math_driver

Overview:
- Host-side initiator for the byte-serial math accumulator unit. It turns one wide command into the sequence of 8-bit opcodes and data bytes the unit needs, and reassembles wide results from the unit's 8-bit output.
- Sits between the host/control logic and the math unit. It drives the unit's op_in and data_in, and reads the unit's data_out.
- Wide operands are loaded one byte at a time using load-low-byte and shift-left-8 ops. Wide results are read out by repeated shift-right-8 while capturing the low byte each cycle.

Parameters:
- BITS, 64, accumulator width of the attached math unit; must be a multiple of 8 and at least 16.
- NBYTES, BITS/8, derived; not overridable.

Ports:
- clk  in  1  clock; shared with the math unit.
- rst  in  1  synchronous reset, active-high (the math unit receives ~rst as rst_n at top level).
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  driver idle and accepting a command.
- cmd_op  in  3  0 LOAD, 1 READ, 2 PEEK, 3 ADD, 4 SHL, 5 SHR, 6 CLEAR, 7 reserved (NOP).
- cmd_data  in  BITS  LOAD: operand; ADD/SHL/SHR: bits [7:0] only; others: ignored.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  BITS  result; valid only while rsp_valid is high.
- unit_op  out  8  connects to the math unit's op_in.
- unit_wdata  out  8  connects to the math unit's data_in.
- unit_rdata  in  8  connects to the math unit's data_out (accumulator [7:0]).

Behaviour:
- Reset: state IDLE; unit_op=8'h00; unit_wdata=0; rsp_valid=0; rsp_data=0; capture buffer=0; byte counter=0.
- unit_op and unit_wdata are registered. An op the driver presents in cycle n takes effect in the unit at the end of cycle n. Its result is visible on unit_rdata in cycle n+1.
- cmd_ready=1 only in IDLE. A command is accepted on the edge where cmd_valid&&cmd_ready. Op cycles run from t+1 to t+K. DONE is cycle t+K+1. The driver is back in IDLE, with cmd_ready=1, at t+K+2.
- In every non-op cycle (IDLE, DONE, reset) unit_op=00.
- States: IDLE -> LOADSEQ | READSEQ | SINGLE | DONE; READSEQ -> LOADSEQ (PEEK) or DONE; LOADSEQ -> DONE; SINGLE -> DONE; DONE -> IDLE.
- LOAD (K=2*NBYTES-1):
  - For i = NBYTES-1 down to 0: issue 02 with data=cmd_data[8i+7:8i].
  - After each of these except i=0, issue 04 with data=8'h08.
  - No CLEAR is needed: the prior accumulator contents are fully shifted out.
  - The operand is latched at accept, so cmd_data may change afterwards.
- READ (K=NBYTES):
  - Issue 05 with data=8'h08 NBYTES times.
  - In op cycle j (0-based), capture unit_rdata into buffer[8j+7:8j]. This is the pre-shift low byte.
  - Destructive: the accumulator ends at 0.
- PEEK (K=3*NBYTES-1): a READ sequence, then a LOAD sequence of the captured buffer. This restores the accumulator.
- ADD / SHL / SHR / CLEAR (K=1): a single op: 03, 04, or 05 with data=cmd_data[7:0], or 01 with data 00.
- Reserved op 7 (K=0): goes directly to DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle.
  - READ/PEEK: rsp_data=buffer.
  - All other commands: rsp_data={zeros, unit_rdata}, i.e. the new low byte. This value is sampled combinationally in DONE.
- There is no response backpressure. The host must take rsp in the DONE cycle.
- cmd_valid held while busy is ignored; there is no queueing.
- A back-to-back command is accepted in the IDLE cycle that follows DONE.
- Byte counter: width clog2(NBYTES)+1, no wrap. Each sequence loads it at entry and terminates at the terminal count.
- SHL/SHR amounts of BITS or more are passed through unchanged. The unit zeroes the accumulator; the driver does no checking.
- Reset mid-sequence:
  - Aborts immediately. unit_op=00 from the next cycle.
  - No rsp_valid is generated.
  - Accumulator contents are undefined unless the unit is reset at the same time (the normal case).
- rst takes priority over a simultaneous cmd_valid.

Decomposition:
- Shared package math_pkg:
  - Unit opcode constants: OP_NOP=00, OP_CLR=01, OP_LDB=02, OP_ADD=03, OP_SHL=04, OP_SHR=05.
  - Host command encodings: CMD_LOAD..CMD_CLEAR.
  - Driver state encoding.
  - The math unit is updated to use the same opcode constants.
- No sub-module: the FSM, byte counter and capture shift register stay in one module.

Test Plan (BITS=64, driver connected to the real math unit):
- LOAD 0x0123456789ABCDEF:
  - Op stream 02/01, 04/08, 02/23, 04/08 ... 02/EF (15 ops).
  - rsp_valid at t+16 with rsp_data=0xEF.
  - A following READ returns 0x0123456789ABCDEF; a second READ returns 0.
- LOAD 0xFEDCBA9876543210, then PEEK:
  - rsp_data=0xFEDCBA9876543210 at t+24.
  - A subsequent READ returns the same value.
- LOAD 0xFF, ADD 0xFF:
  - rsp_data=0xFE.
  - READ returns 0x1FE.
- LOAD 0x0F, SHL 4:
  - rsp_data=0xF0.
  - SHR 64 gives rsp_data=0; READ returns 0.
- cmd_valid held high with four queued LOAD/ADD/READ/CLEAR commands:
  - cmd_ready low during ops.
  - Exactly one accept per command, and one rsp_valid pulse each.
  - Reserved op 7 gives rsp_valid at t+1.
- rst asserted at op cycle 5 of a LOAD:
  - unit_op=00, cmd_ready=1 and rsp_valid=0 on the next cycle.
  - A new LOAD/READ then round-trips correctly.
